// File: rtl/butterfly_pair_stage.sv
// Radix-2 butterfly on operand pairs popped from a first-word-fall-through FIFO.
// Produces y0 = a + b*w and y1 = a - b*w, both saturated, on a valid/ready port.
module butterfly_pair_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int TW_WIDTH   = 8,
  parameter int TW_FRAC    = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  input  logic [TW_WIDTH-1:0]   tw,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   y0,
  output logic [DATA_WIDTH:0]   y1,
  output logic [CNT_WIDTH-1:0]  pair_cnt
);

  // state | meaning
  // S_A   | waiting to pop operand a
  // S_B   | a held, waiting to pop operand b and twiddle
  // S_MUL | form product, sum/difference and saturate into y0/y1
  // S_OUT | result presented, waiting for out_ready
  typedef enum logic [1:0] {S_A, S_B, S_MUL, S_OUT} state_t;

  localparam int PW = DATA_WIDTH + TW_WIDTH;
  localparam int SW = PW + 1;
  localparam int OW = DATA_WIDTH + 1;

  localparam logic [OW-1:0] Y_MAX = {1'b0, {DATA_WIDTH{1'b1}}};
  localparam logic [OW-1:0] Y_MIN = {1'b1, {DATA_WIDTH{1'b0}}};

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] a_reg, b_reg;
  logic signed [TW_WIDTH-1:0]   w_reg;
  logic signed [PW-1:0]         b_ext, w_ext, prod, quo;
  logic signed [SW-1:0]         a_ext, q_ext, s0, s1;

  // Sum/difference are one bit wider than the product so they can never overflow.
  function automatic logic [OW-1:0] sat(input logic [SW-1:0] v);
    logic [SW-OW:0] hi;
    hi = v[SW-1:OW-1];
    if ((&hi) || (~|hi)) return v[OW-1:0];
    else if (v[SW-1])    return Y_MIN;
    else                 return Y_MAX;
  endfunction

  assign b_ext = {{TW_WIDTH{b_reg[DATA_WIDTH-1]}}, b_reg};
  assign w_ext = {{DATA_WIDTH{w_reg[TW_WIDTH-1]}}, w_reg};
  assign prod  = b_ext * w_ext;
  assign quo   = prod >>> TW_FRAC;
  assign a_ext = {{(SW-DATA_WIDTH){a_reg[DATA_WIDTH-1]}}, a_reg};
  assign q_ext = {quo[PW-1], quo};
  assign s0    = a_ext + q_ext;
  assign s1    = a_ext - q_ext;

  always_comb begin
    fifo_re = !rst && ((state == S_A) || (state == S_B)) && !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_A:     if (fifo_re)   state_nxt = S_B;
      S_B:     if (fifo_re)   state_nxt = S_MUL;
      S_MUL:                  state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_A;
      default:                state_nxt = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      w_reg     <= '0;
      y0        <= '0;
      y1        <= '0;
      out_valid <= 1'b0;
      pair_cnt  <= '0;
    end else begin
      case (state)
        S_A: begin
          if (fifo_re) a_reg <= fifo_data;
        end
        S_B: begin
          if (fifo_re) begin
            b_reg <= fifo_data;
            w_reg <= tw;
          end
        end
        S_MUL: begin
          y0        <= sat(s0);
          y1        <= sat(s1);
          out_valid <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pair_cnt  <= pair_cnt + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_butterfly_pair_stage.sv
// Directed bench for butterfly_pair_stage: queue-backed FWFT FIFO model,
// hand-computed results, latency, backpressure, gap and reset cases.
module tb_butterfly_pair_stage;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty;
  logic [7:0]        fifo_data;
  logic              fifo_re;
  logic signed [7:0] tw;
  logic              out_valid;
  logic              out_ready;
  logic signed [8:0] y0, y1;
  logic [15:0]       pair_cnt;

  butterfly_pair_stage #(
    .DATA_WIDTH(8), .TW_WIDTH(8), .TW_FRAC(6), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_re(fifo_re), .tw(tw), .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  int fq[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_pop = -10;
  int prev_pop = -10;
  logic s_re, s_valid;
  int s_y0, s_y1, s_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    int v;
    fifo_empty = (fq.size() == 0);
    v = (fq.size() != 0) ? fq[0] : 0;
    fifo_data = v[7:0];
  endtask

  // One clock: sample at negedge, let the edge happen, then retire a pop.
  task automatic cycle();
    cyc++;
    @(negedge clk);
    s_re    = fifo_re;
    s_valid = out_valid;
    s_y0    = int'(y0);
    s_y1    = int'(y1);
    s_cnt   = int'(pair_cnt);
    @(posedge clk);
    #1;
    if (s_re) begin
      if (fq.size() > 0) void'(fq.pop_front());
      prev_pop = last_pop;
      last_pop = cyc;
    end
    drive_fifo();
  endtask

  task automatic wait_result(input string tag, input int ey0, input int ey1);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (s_valid) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_valid"}, int'(seen), 1);
    chk({tag, "_y0"}, s_y0, ey0);
    chk({tag, "_y1"}, s_y1, ey1);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    tw = 8'sd64;
    fq.push_back(10);
    fq.push_back(3);
    drive_fifo();

    // reset: no pops, everything cleared
    cycle();
    chk("rst_re", int'(s_re), 0);
    cycle();
    chk("rst_re2", int'(s_re), 0);
    chk("rst_valid", int'(s_valid), 0);
    chk("rst_y0", s_y0, 0);
    chk("rst_y1", s_y1, 0);
    chk("rst_cnt", s_cnt, 0);
    rst = 1'b0;

    // basic: 10 + 3*1.0, latency
    wait_result("basic", 13, 7);
    chk("basic_pops_consec", last_pop - prev_pop, 1);
    chk("basic_latency", cyc - last_pop, 2);
    cycle();
    chk("basic_cnt", s_cnt, 1);
    chk("basic_valid_drop", int'(s_valid), 0);
    chk("basic_idle_re", int'(s_re), 0);

    // negative / floor: -5 + floor(4*-0.5)
    tw = -8'sd32;
    fq.push_back(-5);
    fq.push_back(4);
    drive_fifo();
    wait_result("neg", -7, -3);

    // saturation: 127 + floor(127*127/64)=379 -> 255
    tw = 8'sd127;
    fq.push_back(127);
    fq.push_back(127);
    drive_fifo();
    wait_result("sat", 255, -125);
    cycle();
    chk("sat_cnt", s_cnt, 3);

    // backpressure: second pair queued behind the stalled result
    out_ready = 1'b0;
    tw = 8'sd32;
    fq.push_back(30);
    fq.push_back(64);
    fq.push_back(5);
    fq.push_back(5);
    drive_fifo();
    wait_result("bp", 62, -2);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_valid", int'(s_valid), 1);
      chk("bp_hold_y0", s_y0, 62);
      chk("bp_hold_y1", s_y1, -2);
      chk("bp_hold_re", int'(s_re), 0);
      chk("bp_hold_cnt", s_cnt, 3);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_hs_valid", int'(s_valid), 1);
    chk("bp_hs_re", int'(s_re), 0);
    cycle();
    chk("bp_reassert_re", int'(s_re), 1);
    chk("bp_cnt", s_cnt, 4);
    chk("bp_valid_drop", int'(s_valid), 0);
    wait_result("bp2", 7, 3);

    // empty gap between a and b
    fq.push_back(20);
    drive_fifo();
    cycle();
    chk("gap_pop_a", int'(s_re), 1);
    chk("gap_cnt", s_cnt, 5);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("gap_re", int'(s_re), 0);
    end
    tw = 8'sd64;
    fq.push_back(2);
    drive_fifo();
    wait_result("gap", 22, 18);
    cycle();
    chk("gap_cnt2", s_cnt, 6);

    // reset mid-pair: a=50 popped then discarded
    fq.push_back(50);
    drive_fifo();
    cycle();
    chk("mid_pop_a", int'(s_re), 1);
    fq.push_back(1);
    fq.push_back(1);
    drive_fifo();
    rst = 1'b1;
    cycle();
    chk("mid_rst_re", int'(s_re), 0);
    rst = 1'b0;
    cycle();
    chk("mid_after_valid", int'(s_valid), 0);
    chk("mid_after_cnt", s_cnt, 0);
    chk("mid_after_re", int'(s_re), 1);
    wait_result("mid", 2, 0);
    cycle();
    chk("mid_cnt", s_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/butterfly_pair_stage.md
Name: butterfly_pair_stage

Overview:
Downstream consumer of the operand FIFO. It pops operands in pairs (a, b), applies one radix-2 butterfly with a signed fixed-point twiddle (y0 = a + b·w, y1 = a − b·w), and presents the result on a valid/ready output port. The FIFO read is first-word-fall-through: data is valid in the same cycle read-enable is asserted while the FIFO is not empty.

Parameters:
DATA_WIDTH, 8, signed operand width of FIFO words.
TW_WIDTH, 8, signed twiddle width.
TW_FRAC, 6, twiddle fraction bits; w = 2^TW_FRAC represents 1.0.
CNT_WIDTH, 16, width of the completed-pair counter.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
fifo_empty  in  1  upstream FIFO empty flag.
fifo_data  in  DATA_WIDTH  upstream FIFO head word, signed, valid when !fifo_empty.
fifo_re  out  1  pop request to FIFO; combinational.
tw  in  TW_WIDTH  signed twiddle, sampled when operand b is popped.
out_valid  out  1  result valid.
out_ready  in  1  downstream accept.
y0  out  DATA_WIDTH+1  signed a + b·w, registered.
y1  out  DATA_WIDTH+1  signed a − b·w, registered.
pair_cnt  out  CNT_WIDTH  number of results accepted since reset; wraps.

Behaviour:
- FSM states: S_A (fetch a), S_B (fetch b), S_MUL (compute), S_OUT (present result).
- fifo_re = !rst && (state==S_A || state==S_B) && !fifo_empty. It is never asserted in S_MUL or S_OUT.
- S_A: if fifo_re, capture fifo_data into a_reg and go to S_B; otherwise stay.
- S_B: if fifo_re, capture fifo_data into b_reg, capture tw into w_reg, and go to S_MUL; otherwise stay. A gap between a and b is allowed indefinitely, and a_reg is held.
- S_MUL:
  - p = b_reg·w_reg, full signed product of DATA_WIDTH+TW_WIDTH bits.
  - q = p >>> TW_FRAC (arithmetic shift, floor rounding).
  - s0 = a + q and s1 = a − q, computed sign-extended with no intermediate overflow.
  - y0 and y1 get s0 and s1 saturated to the signed DATA_WIDTH+1 range [−2^DATA_WIDTH, 2^DATA_WIDTH−1].
  - Set out_valid=1 and go to S_OUT.
- S_OUT: y0, y1 and out_valid are held stable while out_ready=0. When out_ready=1, that cycle is the handshake: out_valid←0, pair_cnt←pair_cnt+1 (wraps at 2^CNT_WIDTH), go to S_A.
- Latency: with back-to-back data and out_ready=1:
  - a is popped in cycle t and b in cycle t+1.
  - out_valid is high in cycle t+3.
  - The next pop of a is in cycle t+4, giving one pair per 4 cycles.
- out_ready is ignored when out_valid=0.
- Reset values: state=S_A, out_valid=0, y0=0, y1=0, pair_cnt=0, a_reg, b_reg and w_reg=0. fifo_re=0 during rst.
- Reset mid-operation: any partially fetched pair or pending result is discarded, and words already popped are not re-read. The first pop after rst deasserts is treated as a.
- fifo_empty is sampled only in S_A and S_B. fifo_data and tw are don't-care in other states.

Test Plan:
Basic (DATA_WIDTH=8, TW_FRAC=6): FIFO holds 10, 3; tw=64; out_ready=1 -> fifo_re high two consecutive cycles; out_valid two cycles after the second pop; y0=13, y1=7; pair_cnt=1.
Negative/rounding: FIFO −5, 4; tw=−32 -> q=−2; y0=−7, y1=−3.
Saturation: FIFO 127, 127; tw=127 -> q=252; y0=255 (saturated from 379), y1=−125.
Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, then 1 -> y0/y1 stable for all 6 cycles; fifo_re=0 throughout; pair_cnt increments once; fifo_re reasserts the cycle after the handshake.
Empty gap: pop a=20; keep fifo_empty=1 for 4 cycles; then supply b=2 with tw=64 -> fifo_re=0 during the gap; result y0=22, y1=18.
Reset mid-pair: pop a=50; assert rst one cycle; then supply 1, 1 with tw=64 -> out_valid=0 and pair_cnt=0 after reset; next result y0=2, y1=0 (50 discarded).
